icache_fetch_responder: RTL

// Responder side of the fetch request interface: accepts PC fetch requests from the first fetch

---
 rtl/icache_fetch_responder.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/icache_fetch_responder.sv
// Fetch responder: serves fetch-stage-1 PC requests from a one-line buffer,
// refilling from the icache/memory port on a miss, with kill and flush control.
module icache_fetch_responder #(
    parameter int ADDR_W     = 40,
    parameter int LINE_BYTES = 16
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    req_valid_i,
    input  logic [ADDR_W-1:0]       req_vaddr_i,
    input  logic                    req_invalidate_icache_i,
    input  logic                    req_invalidate_buffer_i,
    input  logic                    req_inval_fetch_i,
    output logic                    busy_o,
    output logic                    mem_req_valid_o,
    input  logic                    mem_req_ready_i,
    output logic [ADDR_W-1:0]       mem_req_addr_o,
    input  logic                    mem_resp_valid_i,
    input  logic [8*LINE_BYTES-1:0] mem_resp_data_i,
    input  logic                    mem_resp_xcpt_i,
    output logic                    icache_flush_o,
    output logic                    resp_valid_o,
    output logic [31:0]             resp_instr_o,
    output logic [ADDR_W-1:0]       resp_vaddr_o,
    output logic                    resp_xcpt_o
);

    localparam int OFF = $clog2(LINE_BYTES);
    localparam int LW  = 8 * LINE_BYTES;
    localparam int TW  = ADDR_W - OFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_KILL,
        S_FLUSH
    } state_e;

    state_e            state_q, state_d;
    logic              bvalid_q, bvalid_d;
    logic [TW-1:0]     btag_q, btag_d;
    logic [LW-1:0]     bdata_q, bdata_d;
    logic              flush_q, flush_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rvalid_q, rvalid_d;
    logic [31:0]       rinstr_q, rinstr_d;
    logic [ADDR_W-1:0] rvaddr_q, rvaddr_d;
    logic              rxcpt_q, rxcpt_d;

    logic hit;
    logic fill_ok;

    function automatic logic [31:0] wsel(input logic [LW-1:0] line,
                                         input logic [ADDR_W-1:0] a);
        return line[{a[OFF-1:2], 5'b0} +: 32];
    endfunction

    assign hit     = bvalid_q && (btag_q == req_vaddr_i[ADDR_W-1:OFF]);
    // Data returning while a flush is pending predates the flush: never keep it.
    assign fill_ok = !flush_q && !req_invalidate_icache_i;

    // Next-state, buffer update and registered response selection.
    always_comb begin
        state_d  = state_q;
        bvalid_d = bvalid_q;
        btag_d   = btag_q;
        bdata_d  = bdata_q;
        flush_d  = flush_q;
        addr_d   = addr_q;
        rvalid_d = 1'b0;
        rinstr_d = rinstr_q;
        rvaddr_d = rvaddr_q;
        rxcpt_d  = rxcpt_q;
        if (req_invalidate_buffer_i || req_invalidate_icache_i) bvalid_d = 1'b0;
        if (req_invalidate_icache_i) flush_d = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                if (flush_q || req_invalidate_icache_i) begin
                    state_d = S_FLUSH;
                    flush_d = 1'b0;
                end else if (req_valid_i) begin
                    if (hit && !req_invalidate_buffer_i) begin
                        rvalid_d = 1'b1;
                        rinstr_d = wsel(bdata_q, req_vaddr_i);
                        rvaddr_d = req_vaddr_i;
                        rxcpt_d  = 1'b0;
                    end else begin
                        addr_d  = req_vaddr_i;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (req_inval_fetch_i) begin
                    state_d = mem_req_ready_i ? S_KILL : S_IDLE;
                end else if (mem_req_ready_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_resp_valid_i) begin
                    state_d = S_IDLE;
                    if (!req_inval_fetch_i) begin
                        rvalid_d = 1'b1;
                        rvaddr_d = addr_q;
                        if (mem_resp_xcpt_i) begin
                            rinstr_d = 32'h0;
                            rxcpt_d  = 1'b1;
                            bvalid_d = 1'b0;
                        end else begin
                            rinstr_d = wsel(mem_resp_data_i, addr_q);
                            rxcpt_d  = 1'b0;
                            if (fill_ok) begin
                                bvalid_d = 1'b1;
                                btag_d   = addr_q[ADDR_W-1:OFF];
                                bdata_d  = mem_resp_data_i;
                            end
                        end
                    end
                end else if (req_inval_fetch_i) begin
                    state_d = S_KILL;
                end
            end
            S_KILL: begin
                if (mem_resp_valid_i) state_d = S_IDLE;
            end
            S_FLUSH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q  <= S_IDLE;
            bvalid_q <= 1'b0;
            btag_q   <= '0;
            bdata_q  <= '0;
            flush_q  <= 1'b0;
            addr_q   <= '0;
            rvalid_q <= 1'b0;
            rinstr_q <= '0;
            rvaddr_q <= '0;
            rxcpt_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            bvalid_q <= bvalid_d;
            btag_q   <= btag_d;
            bdata_q  <= bdata_d;
            flush_q  <= flush_d;
            addr_q   <= addr_d;
            rvalid_q <= rvalid_d;
            rinstr_q <= rinstr_d;
            rvaddr_q <= rvaddr_d;
            rxcpt_q  <= rxcpt_d;
        end
    end

    assign busy_o          = (state_q != S_IDLE);
    assign mem_req_valid_o = (state_q == S_REQ);
    assign mem_req_addr_o  = {addr_q[ADDR_W-1:OFF], {OFF{1'b0}}};
    assign icache_flush_o  = (state_q == S_FLUSH);
    assign resp_valid_o    = rvalid_q;
    assign resp_instr_o    = rinstr_q;
    assign resp_vaddr_o    = rvaddr_q;
    assign resp_xcpt_o     = rxcpt_q;

endmodule
